l1_cache_ctrl: RTL and testbench
================================

L1_CACHE_CTRL -- requirements
Module: l1_cache_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, 32, byte-address width.
REQ-002 SHALL have parameter DATA_WIDTH, 32, word/line width in bits; power of two, >=8.
REQ-003 SHALL have parameter NUM_SETS, 16, direct-mapped line count; power of two, >=2.
REQ-004 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port req_valid  input  1  CPU request present.
REQ-007 SHALL have port req_we  input  1  1=write, 0=read.
REQ-008 SHALL have port req_addr  input  ADDR_WIDTH  byte address; offset bits ignored.
REQ-009 SHALL have port req_wdata  input  DATA_WIDTH  write data.
REQ-010 SHALL have port rsp_valid  output  1  one-cycle pulse, request complete.
REQ-011 SHALL have port rsp_rdata  output  DATA_WIDTH  read data, valid with rsp_valid.
REQ-012 SHALL have port hit_miss  output  2  00 idle, 01 hit, 10 miss.
REQ-013 SHALL have port stall  output  1  high = request not accepted.
REQ-014 SHALL have ports mem_req_valid  output  1 / mem_req_we  output  1 / mem_addr  output  ADDR_WIDTH / mem_wdata  output  DATA_WIDTH, backing-memory request.
REQ-015 SHALL have ports mem_ready  input  1 / mem_rdata  input  DATA_WIDTH, backing-memory completion and fill data.

Function
REQ-016 SHALL split address as offset=log2(DATA_WIDTH/8) LSBs, index=next log2(NUM_SETS) bits, tag=remaining MSBs.
REQ-017 SHALL keep per line: valid, dirty, tag, data; write-back, write-allocate policy.
REQ-018 SHALL implement FSM IDLE, COMPARE, WRITEBACK, ALLOCATE.
REQ-019 IDLE: stall=0; req_valid=1 registers addr/we/wdata, next state COMPARE.
REQ-020 COMPARE: stall=1; hit (valid && tag match) drives hit_miss=01, rsp_valid=1, next IDLE; hit latency = 1 cycle after acceptance.
REQ-021 COMPARE write hit SHALL store wdata and set dirty; read hit SHALL drive line data on rsp_rdata.
REQ-022 COMPARE miss drives hit_miss=10 for that cycle; next WRITEBACK if victim valid && dirty, else ALLOCATE.
REQ-023 WRITEBACK: mem_req_valid=1, mem_req_we=1, mem_addr={victim tag,index,0}, mem_wdata=victim data, held stable until mem_ready; then ALLOCATE.
REQ-024 ALLOCATE: mem_req_valid=1, mem_req_we=0, mem_addr={req tag,index,0} until mem_ready; line filled from mem_rdata, valid=1, dirty=0, tag updated; then COMPARE (guaranteed hit).
REQ-025 stall SHALL be 1 in every state except IDLE; req_* ignored while stall=1.
REQ-026 hit_miss SHALL be 00 outside COMPARE; rsp_valid SHALL never assert outside COMPARE.
REQ-027 mem_ready asserted while mem_req_valid=0 SHALL be ignored.
REQ-028 Index wrap: highest index (NUM_SETS-1) SHALL map with no aliasing to index 0.

Reset
REQ-029 reset SHALL asynchronously force IDLE, clear all valid and dirty bits, and drive all outputs to 0; data/tag arrays not reset.
REQ-030 reset mid WRITEBACK/ALLOCATE SHALL drop mem_req_valid immediately; in-flight transaction abandoned, no line updated.

Configuration
REQ-031 With L1_CACHE_STATS_EN defined, SHALL add outputs hit_count, miss_count (32 b each, reset 0, +1 per COMPARE hit/first-miss cycle, saturating at all-ones); without it, ports and counters absent.
REQ-032 Post-fill COMPARE hit SHALL NOT increment hit_count.

Structure
REQ-033 Shared package l1_cache_pkg SHALL hold FSM state typedef and hit_miss encoding constants (HM_IDLE, HM_HIT, HM_MISS).
REQ-034 Tag/valid/dirty/data storage SHALL be sub-module l1_cache_array (1 read + 1 write port, combinational read).

Verification (DATA_WIDTH 32, NUM_SETS 16, mem_ready one cycle after request)
REQ-035 Write 0xDEADBEEF @0x10000000 on empty cache -> miss, ALLOCATE read of 0x10000000, then hit, rsp_valid; line dirty.
REQ-036 Read @0x10000000 next -> hit_miss=01, rsp_rdata=0xDEADBEEF one cycle after acceptance, no memory request.
REQ-037 Read @0x20000000 (same index 0) -> hit_miss=10, WRITEBACK addr 0x10000000 data 0xDEADBEEF, then ALLOCATE 0x20000000, rsp_rdata=mem_rdata.
REQ-038 Read @0x1000003C (index 15) then @0x10000000 -> both independent lines, no eviction of index 15.
REQ-039 reset asserted during ALLOCATE with mem_ready held low -> mem_req_valid=0, stall=0 same cycle; following read @0x20000000 misses.
REQ-040 With L1_CACHE_STATS_EN: sequence of REQ-035..037 -> hit_count=1, miss_count=2.

Source files
------------

// File: rtl/l1_cache_pkg.sv
// l1_cache_pkg
// Shared definitions for the L1 cache controller slice.
//   cache_state_t : controller FSM states (IDLE, COMPARE, WRITEBACK, ALLOCATE)
//   HM_*          : encodings driven on the hit_miss status output
package l1_cache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_COMPARE   = 2'd1,
    ST_WRITEBACK = 2'd2,
    ST_ALLOCATE  = 2'd3
  } cache_state_t;

  localparam logic [1:0] HM_IDLE = 2'b00;
  localparam logic [1:0] HM_HIT  = 2'b01;
  localparam logic [1:0] HM_MISS = 2'b10;

endpackage

// File: rtl/l1_cache_array.sv
// l1_cache_array
// Direct-mapped line storage: valid, dirty, tag and data per set.
// One combinational read port and one synchronous write port.
//   clk, reset           : clock; async active-high reset clears valid/dirty only
//   rd_idx               : set being examined
//   rd_valid/rd_dirty    : status bits of that set
//   rd_tag/rd_data       : stored tag and line data of that set
//   wr_en/wr_idx         : write strobe and target set (write also marks line valid)
//   wr_tag/wr_data       : new tag and line data
//   wr_dirty             : new dirty bit
module l1_cache_array
  import l1_cache_pkg::*;
#(
  parameter int TAG_W      = 26,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SETS   = 16,
  parameter int IDX_W      = $clog2(NUM_SETS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic                  rd_valid,
  output logic                  rd_dirty,
  output logic [TAG_W-1:0]      rd_tag,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [TAG_W-1:0]      wr_tag,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_dirty
);

  logic [NUM_SETS-1:0]   valid_q;
  logic [NUM_SETS-1:0]   dirty_q;
  logic [TAG_W-1:0]      tag_mem  [NUM_SETS];
  logic [DATA_WIDTH-1:0] data_mem [NUM_SETS];

  // Status bits are the only state that reset has to clear; every write
  // installs a valid line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= 1'b1;
      dirty_q[wr_idx] <= wr_dirty;
    end
  end

  // Tag and data payload are qualified by valid, so they are left unreset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_dirty = dirty_q[rd_idx];
  assign rd_tag   = tag_mem[rd_idx];
  assign rd_data  = data_mem[rd_idx];

endmodule

// File: rtl/l1_cache_ctrl.sv
// l1_cache_ctrl
// Direct-mapped, write-back, write-allocate L1 cache controller.
//   clk, reset                  : clock; async active-high reset
//   req_valid/req_we            : CPU request strobe and direction (1 = write)
//   req_addr/req_wdata          : byte address (offset ignored) and write data
//   rsp_valid/rsp_rdata         : one-cycle completion pulse and read data
//   hit_miss                    : 00 idle, 01 hit, 10 miss (COMPARE only)
//   stall                       : high whenever a new request cannot be taken
//   mem_req_valid/mem_req_we    : backing-memory request and direction
//   mem_addr/mem_wdata          : line address and write-back data
//   mem_ready/mem_rdata         : backing-memory completion and fill data
// Optional build macro L1_CACHE_STATS_EN adds saturating hit_count and
// miss_count outputs.
module l1_cache_ctrl
  import l1_cache_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SETS   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            hit_miss,
  output logic                  stall,
  output logic                  mem_req_valid,
  output logic                  mem_req_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef L1_CACHE_STATS_EN
  ,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
`endif
);

  localparam int OFF_W = $clog2(DATA_WIDTH / 8);
  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = ADDR_WIDTH - OFF_W - IDX_W;

  cache_state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  we_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  logic [IDX_W-1:0]      req_idx;
  logic [TAG_W-1:0]      req_tag;
  logic [ADDR_WIDTH-1:0] req_line_addr;
  logic [ADDR_WIDTH-1:0] victim_addr;

  logic                  rd_valid, rd_dirty;
  logic [TAG_W-1:0]      rd_tag;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  wr_en, wr_dirty;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  line_hit;
  logic                  accept;

  // Offset bits never select anything in a one-word line; folding the whole
  // register here keeps every bit referenced for any DATA_WIDTH.
  logic unused_offset;
  assign unused_offset = ^addr_q;

  assign req_idx  = addr_q[OFF_W +: IDX_W];
  assign req_tag  = addr_q[ADDR_WIDTH-1 -: TAG_W];
  assign line_hit = rd_valid && (rd_tag == req_tag);

  // Line addresses carry zero offset bits; built by shift so OFF_W may be 0.
  assign req_line_addr = ADDR_WIDTH'({req_tag, req_idx}) << OFF_W;
  assign victim_addr   = ADDR_WIDTH'({rd_tag, req_idx}) << OFF_W;

  l1_cache_array #(
    .TAG_W     (TAG_W),
    .DATA_WIDTH(DATA_WIDTH),
    .NUM_SETS  (NUM_SETS),
    .IDX_W     (IDX_W)
  ) u_array (
    .clk     (clk),
    .reset   (reset),
    .rd_idx  (req_idx),
    .rd_valid(rd_valid),
    .rd_dirty(rd_dirty),
    .rd_tag  (rd_tag),
    .rd_data (rd_data),
    .wr_en   (wr_en),
    .wr_idx  (req_idx),
    .wr_tag  (req_tag),
    .wr_data (wr_data),
    .wr_dirty(wr_dirty)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request capture; the registered copy drives the array lookup so later
  // changes on req_* while stalled have no effect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else if (accept) begin
      addr_q  <= req_addr;
      we_q    <= req_we;
      wdata_q <= req_wdata;
    end
  end

  // Next-state and outputs. All outputs are decoded from the state, so an
  // asynchronous reset (state forced to IDLE) zeroes them immediately and
  // abandons any memory transaction without touching the array.
  always_comb begin
    state_d       = state_q;
    accept        = 1'b0;
    stall         = 1'b1;
    rsp_valid     = 1'b0;
    rsp_rdata     = '0;
    hit_miss      = HM_IDLE;
    mem_req_valid = 1'b0;
    mem_req_we    = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    wr_en         = 1'b0;
    wr_data       = wdata_q;
    wr_dirty      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        stall = 1'b0;
        if (req_valid) begin
          accept  = 1'b1;
          state_d = ST_COMPARE;
        end
      end
      ST_COMPARE: begin
        if (line_hit) begin
          hit_miss  = HM_HIT;
          rsp_valid = 1'b1;
          state_d   = ST_IDLE;
          if (we_q) begin
            wr_en    = 1'b1;
            wr_dirty = 1'b1;
          end else begin
            rsp_rdata = rd_data;
          end
        end else begin
          hit_miss = HM_MISS;
          state_d  = (rd_valid && rd_dirty) ? ST_WRITEBACK : ST_ALLOCATE;
        end
      end
      ST_WRITEBACK: begin
        mem_req_valid = 1'b1;
        mem_req_we    = 1'b1;
        mem_addr      = victim_addr;
        mem_wdata     = rd_data;
        if (mem_ready) begin
          state_d = ST_ALLOCATE;
        end
      end
      ST_ALLOCATE: begin
        mem_req_valid = 1'b1;
        mem_addr      = req_line_addr;
        if (mem_ready) begin
          wr_en   = 1'b1;
          wr_data = mem_rdata;
          state_d = ST_COMPARE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef L1_CACHE_STATS_EN
  // Marks the COMPARE that follows a fill so its guaranteed hit is not
  // counted as a second event for the same request.
  logic fill_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fill_q <= 1'b0;
    end else if (accept) begin
      fill_q <= 1'b0;
    end else if (state_q == ST_ALLOCATE && mem_ready) begin
      fill_q <= 1'b1;
    end
  end

  // Saturating event counters; a miss is only ever seen on the first
  // COMPARE of a request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state_q == ST_COMPARE) begin
      if (line_hit && !fill_q && hit_count != '1) begin
        hit_count <= hit_count + 32'd1;
      end
      if (!line_hit && miss_count != '1) begin
        miss_count <= miss_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_l1_cache_ctrl.sv
// tb_l1_cache_ctrl
// Self-checking bench for l1_cache_ctrl (DATA_WIDTH 32, NUM_SETS 16).
// A responder models backing memory answering one cycle after each request.
// Directed table rows, a reset-abandon sequence and a random run checked
// against a set-level reference model of the cache.
// Define L1_CACHE_STATS_EN to also check the statistics counters.
module tb_l1_cache_ctrl;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  hit_miss;
  logic        stall;
  logic        mem_req_valid;
  logic        mem_req_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
`ifdef L1_CACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  l1_cache_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .hit_miss     (hit_miss),
    .stall        (stall),
    .mem_req_valid(mem_req_valid),
    .mem_req_we   (mem_req_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_ready    (mem_ready),
    .mem_rdata    (mem_rdata)
`ifdef L1_CACHE_STATS_EN
    ,
    .hit_count    (hit_count),
    .miss_count   (miss_count)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  // Backing memory and its request log
  logic [31:0] mem_model [int unsigned];
  bit          mem_hold = 1'b0;
  int          mem_age  = 0;
  int          wb_count = 0;
  int          rd_count = 0;
  logic [31:0] last_wb_addr, last_wb_data, last_rd_addr;

  // Reference model: per-set status plus the architecturally visible memory
  bit          ref_valid [16];
  bit          ref_dirty [16];
  logic [25:0] ref_tag   [16];
  logic [31:0] truth     [int unsigned];

  typedef struct {
    logic [1:0]  hm;
    logic [31:0] rdata;
    int          lat;
    int          nwb;
    int          nrd;
    logic [31:0] wb_addr;
    logic [31:0] wb_data;
    logic [31:0] rd_addr;
    bit          timeout;
  } obs_t;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  hm;
    int          lat;
    int          nwb;
    int          nrd;
    logic [31:0] wb_addr;
    logic [31:0] wb_data;
    logic [31:0] rd_addr;
    logic [31:0] rdata;
  } vec_t;

  function automatic logic [31:0] init_val(input int unsigned word);
    return (word * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  function automatic logic [31:0] backing_read(input int unsigned word);
    if (mem_model.exists(word)) return mem_model[word];
    return init_val(word);
  endfunction

  function automatic logic [31:0] truth_read(input int unsigned word);
    if (truth.exists(word)) return truth[word];
    return init_val(word);
  endfunction

  // Memory responder: raises mem_ready on the second falling edge of each
  // request, i.e. the handshake completes one cycle after the request.
  always @(negedge clk) begin
    if (reset || mem_hold || !mem_req_valid || mem_ready) begin
      mem_ready = 1'b0;
      mem_age   = (!reset && !mem_hold && mem_req_valid) ? 1 : 0;
    end else if (mem_age == 0) begin
      mem_age = 1;
    end else begin
      mem_ready = 1'b1;
      mem_age   = 0;
      if (mem_req_we) begin
        mem_model[mem_addr >> 2] = mem_wdata;
        wb_count++;
        last_wb_addr = mem_addr;
        last_wb_data = mem_wdata;
      end else begin
        mem_rdata = backing_read(mem_addr >> 2);
        rd_count++;
        last_rd_addr = mem_addr;
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clearModel();
    for (int i = 0; i < 16; i++) begin
      ref_valid[i] = 1'b0;
      ref_dirty[i] = 1'b0;
      ref_tag[i]   = '0;
    end
    truth.delete();
    mem_model.delete();
  endtask

  task automatic resetDut();
    @(negedge clk);
    reset     = 1'b1;
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    clearModel();
  endtask

  // Issues one request from a falling edge in IDLE and follows it to its
  // response. While stalled, req_valid stays high with junk fields, which
  // the controller must ignore. Returns at a falling edge back in IDLE.
  task automatic applyStimulus(input bit we, input logic [31:0] addr,
                               input logic [31:0] wdata, output obs_t o);
    int wb0, rd0, cyc;
    wb0 = wb_count;
    rd0 = rd_count;
    o.hm = 2'b00;
    checkOutput("idle_stall", {31'b0, stall}, 32'd0);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    @(negedge clk);
    checkOutput("busy_stall", {31'b0, stall}, 32'd1);
    cyc = 1;
    while (!rsp_valid && cyc < 40) begin
      if (o.hm == 2'b00) o.hm = hit_miss;
      req_we    = $urandom_range(0, 1) == 1;
      req_addr  = $urandom;
      req_wdata = $urandom;
      @(negedge clk);
      cyc++;
    end
    if (o.hm == 2'b00) o.hm = hit_miss;
    req_valid = 1'b0;
    o.timeout = !rsp_valid;
    o.lat     = cyc;
    o.rdata   = rsp_rdata;
    o.nwb     = wb_count - wb0;
    o.nrd     = rd_count - rd0;
    o.wb_addr = last_wb_addr;
    o.wb_data = last_wb_data;
    o.rd_addr = last_rd_addr;
    if (o.timeout) checkOutput("rsp_timeout", 32'd1, 32'd0);
    @(negedge clk);
    checkOutput("rsp_pulse", {31'b0, rsp_valid}, 32'd0);
  endtask

  vec_t        tbl [8];
  obs_t        o;
  int unsigned idx, word, vic_word;
  logic [25:0] tg;
  logic [25:0] tag_pool [4];
  logic [31:0] a, wd, exp_rd, exp_wb_addr, exp_wb_data;
  bit          we, exp_hit, exp_wb;
  int          exp_lat;
  int          polls;

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    last_wb_addr = '0;
    last_wb_data = '0;
    last_rd_addr = '0;
    clearModel();

    repeat (3) @(negedge clk);
    checkOutput("rst_stall", {31'b0, stall}, 32'd0);
    checkOutput("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    checkOutput("rst_hit_miss", {30'b0, hit_miss}, 32'd0);
    checkOutput("rst_mem_req_valid", {31'b0, mem_req_valid}, 32'd0);
    checkOutput("rst_mem_addr", mem_addr, 32'd0);
`ifdef L1_CACHE_STATS_EN
    checkOutput("rst_hit_count", hit_count, 32'd0);
    checkOutput("rst_miss_count", miss_count, 32'd0);
`endif
    reset = 1'b0;
    @(negedge clk);

    // Directed rows. Miss latency: 4 cycles without write-back, 6 with.
    tbl[0] = '{1'b1, 32'h1000_0000, 32'hDEAD_BEEF, 2'b10, 4, 0, 1, 32'h0, 32'h0, 32'h1000_0000, 32'h0};
    tbl[1] = '{1'b0, 32'h1000_0000, 32'h0, 2'b01, 1, 0, 0, 32'h0, 32'h0, 32'h0, 32'hDEAD_BEEF};
    tbl[2] = '{1'b0, 32'h2000_0000, 32'h0, 2'b10, 6, 1, 1, 32'h1000_0000, 32'hDEAD_BEEF,
               32'h2000_0000, init_val(32'h2000_0000 >> 2)};
    tbl[3] = '{1'b0, 32'h1000_003C, 32'h0, 2'b10, 4, 0, 1, 32'h0, 32'h0,
               32'h1000_003C, init_val(32'h1000_003C >> 2)};
    tbl[4] = '{1'b0, 32'h1000_0000, 32'h0, 2'b10, 4, 0, 1, 32'h0, 32'h0,
               32'h1000_0000, 32'hDEAD_BEEF};
    tbl[5] = '{1'b0, 32'h1000_003C, 32'h0, 2'b01, 1, 0, 0, 32'h0, 32'h0, 32'h0,
               init_val(32'h1000_003C >> 2)};
    tbl[6] = '{1'b1, 32'h1000_003F, 32'h1234_5678, 2'b01, 1, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0};
    tbl[7] = '{1'b0, 32'h1000_003D, 32'h0, 2'b01, 1, 0, 0, 32'h0, 32'h0, 32'h0, 32'h1234_5678};

    for (int i = 0; i < 8; i++) begin
      applyStimulus(tbl[i].we, tbl[i].addr, tbl[i].wdata, o);
      checkOutput($sformatf("tbl%0d_hit_miss", i), {30'b0, o.hm}, {30'b0, tbl[i].hm});
      checkOutput($sformatf("tbl%0d_latency", i), o.lat, tbl[i].lat);
      checkOutput($sformatf("tbl%0d_writebacks", i), o.nwb, tbl[i].nwb);
      checkOutput($sformatf("tbl%0d_fills", i), o.nrd, tbl[i].nrd);
      if (tbl[i].nwb > 0) begin
        checkOutput($sformatf("tbl%0d_wb_addr", i), o.wb_addr, tbl[i].wb_addr);
        checkOutput($sformatf("tbl%0d_wb_data", i), o.wb_data, tbl[i].wb_data);
      end
      if (tbl[i].nrd > 0) checkOutput($sformatf("tbl%0d_fill_addr", i), o.rd_addr, tbl[i].rd_addr);
      if (!tbl[i].we) checkOutput($sformatf("tbl%0d_rdata", i), o.rdata, tbl[i].rdata);
`ifdef L1_CACHE_STATS_EN
      if (i == 2) begin
        checkOutput("stats_hit_count", hit_count, 32'd1);
        checkOutput("stats_miss_count", miss_count, 32'd2);
      end
`endif
    end

    // Reset while ALLOCATE waits on a memory that never answers.
    resetDut();
    mem_hold  = 1'b1;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 32'h3000_0000;
    @(negedge clk);
    req_valid = 1'b0;
    polls = 0;
    while (!(mem_req_valid && !mem_req_we) && polls < 10) begin
      @(negedge clk);
      polls++;
    end
    checkOutput("alloc_reached", {31'b0, mem_req_valid}, 32'd1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("abort_mem_req_valid", {31'b0, mem_req_valid}, 32'd0);
    checkOutput("abort_stall", {31'b0, stall}, 32'd0);
    checkOutput("abort_mem_addr", mem_addr, 32'd0);
    @(negedge clk);
    reset    = 1'b0;
    mem_hold = 1'b0;
    clearModel();
    @(negedge clk);
    applyStimulus(1'b0, 32'h2000_0000, 32'h0, o);
    checkOutput("post_abort_hit_miss", {30'b0, o.hm}, 32'd2);
    checkOutput("post_abort_rdata", o.rdata, init_val(32'h2000_0000 >> 2));
    applyStimulus(1'b0, 32'h3000_0000, 32'h0, o);
    checkOutput("abandoned_fill_not_kept", {30'b0, o.hm}, 32'd2);
    ref_valid[0] = 1'b1;
    ref_dirty[0] = 1'b0;
    ref_tag[0]   = 26'(32'h3000_0000 >> 6);

    // Random run against the reference model; few tags so sets collide.
    tag_pool[0] = 26'h040_0000;
    tag_pool[1] = 26'h080_0000;
    tag_pool[2] = 26'h000_0001;
    tag_pool[3] = 26'h3FF_FFFF;
    for (int n = 0; n < 80; n++) begin
      tg  = tag_pool[$urandom_range(0, 3)];
      idx = $urandom_range(0, 15);
      a   = {tg, idx[3:0], 2'($urandom_range(0, 3))};
      we  = $urandom_range(0, 9) < 4;
      wd  = $urandom;

      word        = a >> 2;
      exp_hit     = ref_valid[idx] && ref_tag[idx] == tg;
      exp_wb      = !exp_hit && ref_valid[idx] && ref_dirty[idx];
      vic_word    = {ref_tag[idx], 4'(idx)};
      exp_wb_addr = vic_word * 4;
      exp_wb_data = truth_read(vic_word);
      exp_rd      = truth_read(word);
      exp_lat     = exp_hit ? 1 : (exp_wb ? 6 : 4);

      applyStimulus(we, a, wd, o);
      checkOutput($sformatf("rnd%0d_hit_miss", n), {30'b0, o.hm}, exp_hit ? 32'd1 : 32'd2);
      checkOutput($sformatf("rnd%0d_latency", n), o.lat, exp_lat);
      checkOutput($sformatf("rnd%0d_writebacks", n), o.nwb, exp_wb ? 32'd1 : 32'd0);
      checkOutput($sformatf("rnd%0d_fills", n), o.nrd, exp_hit ? 32'd0 : 32'd1);
      if (exp_wb) begin
        checkOutput($sformatf("rnd%0d_wb_addr", n), o.wb_addr, exp_wb_addr);
        checkOutput($sformatf("rnd%0d_wb_data", n), o.wb_data, exp_wb_data);
      end
      if (!we) checkOutput($sformatf("rnd%0d_rdata", n), o.rdata, exp_rd);

      if (!exp_hit) ref_dirty[idx] = 1'b0;
      ref_valid[idx] = 1'b1;
      ref_tag[idx]   = tg;
      if (we) begin
        ref_dirty[idx] = 1'b1;
        truth[word]    = wd;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
